sync_marker_tx: RTL and testbench
=================================

// Module: sync_marker_tx
// PURPOSE
//  Serial framer on the transmit side of the 0111 sync-marker link.
//  - Accepts one DATA_W-bit word per valid/ready handshake.
//  - Emits the 4-bit sync marker 0,1,1,1, then the payload, then an idle gap of zeros.
//  - With bit stuffing compiled in, 0111 never appears on serial_out outside a marker,
//    so an overlapping 0111 sequence detector at the far end fires exactly once per frame.
// PARAMETERS
//  DATA_W      8  payload width in bits (>=2)
//  GAP_CYCLES  2  minimum idle-zero cycles after each frame (>=0)
//  MSB_FIRST   1  1: payload sent from bit DATA_W-1 down to bit 0; 0: bit 0 first
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  tx_data     in   DATA_W  payload word
//  tx_valid    in   1       tx_data valid
//  tx_ready    out  1       block can accept a word this cycle
//  serial_out  out  1       serial line, registered
//  frame_active out 1       1 while a marker or payload bit is on serial_out
//  stuff_out   out  1       1 while the current serial_out bit is a stuffed 0
// BEHAVIOUR
//  - Reset: state IDLE; serial_out=0, frame_active=0, stuff_out=0, tx_ready=1.
//    Internal data, bit index and ones counter cleared.
//    Asserting rst mid-frame aborts the frame; no residual bits are sent after release.
//  - All outputs are registered. tx_ready = (state==IDLE).
//  - States:
//    - IDLE: serial_out=0. On tx_valid&tx_ready at edge E0, capture tx_data and go to SYNC.
//    - SYNC: 4 cycles. serial_out = 0,1,1,1, first bit visible right after E0.
//      frame_active=1. Then go to DATA.
//    - DATA: payload bits in MSB_FIRST order. frame_active=1.
//      After the last payload bit, go to GAP, or to IDLE if GAP_CYCLES==0.
//    - GAP: GAP_CYCLES cycles. serial_out=0, frame_active=0, tx_ready=0. Then go to IDLE.
//  - Latency: 1 cycle from the accepting edge to the first marker bit on serial_out.
//  - Frame length: 4 + DATA_W + nstuff cycles. Idle-to-idle period: frame length + GAP_CYCLES + 1.
//  - Back-to-back: with tx_valid held high, tx_ready is 1 for exactly one cycle between frames.
//  - tx_data may change freely after acceptance; the captured copy is used.
//  - The idle line is 0, so the idle level never completes a 0111 pattern.
// CONFIGURATION
//  - TX_BIT_STUFF_EN defined:
//    - 2-bit ones_cnt counts consecutive payload 1s sent; cleared in SYNC, and on any
//      payload 0 or stuffed 0.
//    - When ones_cnt==2 and another payload bit remains, emit a 0 with stuff_out=1.
//      The bit index does not advance, and ones_cnt is cleared.
//    - No stuff bit follows the final payload bit.
//    - nstuff max = floor((DATA_W-1)/2).
//  - TX_BIT_STUFF_EN undefined:
//    - No stuffing; stuff_out tied 0, nstuff=0, frame is always 4+DATA_W cycles.
//    - The payload may alias the marker; the sender is responsible for avoiding that.
// TESTING
//  1. DATA_W=8, tx_data=8'h00 -> serial 0111_00000000, frame_active 12 cycles,
//     then 2 gap zeros, tx_ready back to 1.
//  2. Stuffing on, 8'hFF -> 0111_11011011011 (15 cycles); stuff_out=1 on frame cycles 7, 10, 13.
//  3. Stuffing on, 8'h77 -> payload 0,1,1,[0],1,0,1,1,[0],1. Model detector fires only at marker end.
//  4. tx_valid held, words A5 then 3C -> two frames separated by exactly 2 zeros + 1 idle cycle;
//     tx_ready high 1 cycle in between.
//  5. rst pulse during payload bit 3 -> serial_out=0, frame_active=0, tx_ready=1 immediately;
//     next word framed cleanly from its marker.
//  6. Random 1000 words with loopback to a 0111 detector -> detection count == frame count
//     (stuffing on).

Source files
------------

// File: rtl/sync_marker_tx.sv
// Transmit framer for the 0111 sync-marker serial link: marker, payload, idle-zero gap.
// Define TX_BIT_STUFF_EN to insert a 0 after two payload 1s so 0111 only appears as the marker.
module sync_marker_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              frame_active,
    output logic              stuff_out
);

`ifdef TX_BIT_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_GAP
    } state_t;

    // The state registers describe the bit currently on serial_out, not the next one.
    state_t            state_q,    state_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [1:0]        ones_q,     ones_d;
    logic [1:0]        sync_cnt_q, sync_cnt_d;
    logic [GAP_W-1:0]  gap_q,      gap_d;
    logic              serial_q,   serial_d;
    logic              active_q,   active_d;
    logic              stuff_q,    stuff_d;
    logic              ready_q,    ready_d;

    logic pay_done;
    logic do_stuff;
    logic pay_bit;
    logic step;

    always_comb begin
        pay_done = (idx_q == IDX_W'(DATA_W));
        do_stuff = STUFF_EN && (ones_q == 2'd2) && !pay_done;
        pay_bit  = MSB_FIRST ? data_q[DATA_W-1] : data_q[0];
        // Last marker bit and every payload cycle pick the next payload/stuff bit.
        step     = (state_q == S_DATA) || ((state_q == S_SYNC) && (sync_cnt_q == 2'd3));

        state_d    = state_q;
        data_d     = data_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        sync_cnt_d = sync_cnt_q;
        gap_d      = gap_q;
        serial_d   = 1'b0;
        active_d   = 1'b0;
        stuff_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d    = S_SYNC;
                    data_d     = tx_data;
                    idx_d      = '0;
                    ones_d     = '0;
                    sync_cnt_d = '0;
                    active_d   = 1'b1;
                end
            end
            S_SYNC: begin
                if (sync_cnt_q != 2'd3) begin
                    sync_cnt_d = sync_cnt_q + 2'd1;
                    serial_d   = 1'b1;
                    active_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (int'(gap_q) + 1 >= GAP_CYCLES) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
            end
        endcase

        if (step) begin
            if (pay_done) begin
                gap_d = '0;
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                state_d  = S_DATA;
                active_d = 1'b1;
                if (do_stuff) begin
                    // Stuffed zero: hold the bit index, restart the run of ones.
                    stuff_d = 1'b1;
                    ones_d  = '0;
                end else begin
                    serial_d = pay_bit;
                    data_d   = MSB_FIRST ? (data_q << 1) : (data_q >> 1);
                    idx_d    = idx_q + IDX_W'(1);
                    ones_d   = pay_bit ? (ones_q + 2'd1) : 2'd0;
                end
            end
        end

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            ones_q     <= '0;
            sync_cnt_q <= '0;
            gap_q      <= '0;
            serial_q   <= 1'b0;
            active_q   <= 1'b0;
            stuff_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            ones_q     <= ones_d;
            sync_cnt_q <= sync_cnt_d;
            gap_q      <= gap_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            stuff_q    <= stuff_d;
            ready_q    <= ready_d;
        end
    end

    assign tx_ready     = ready_q;
    assign serial_out   = serial_q;
    assign frame_active = active_q;
    assign stuff_out    = stuff_q;

endmodule

// File: tb/tb_sync_marker_tx.sv
// Scoreboard bench for sync_marker_tx; follows TX_BIT_STUFF_EN the same way as the design.
module tb_sync_marker_tx;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam bit MSB = 1'b1;
    localparam int NW  = 1000;
`ifdef TX_BIT_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    // One entry per line cycle: {serial_out, frame_active, stuff_out, tx_ready}
    typedef struct packed {
        logic ser;
        logic fa;
        logic stf;
        logic rdy;
    } exp_t;
    localparam exp_t IDLE_E = 4'b0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          serial_out;
    logic          frame_active;
    logic          stuff_out;

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    sync_marker_tx #(
        .DATA_W(DW),
        .GAP_CYCLES(GAP),
        .MSB_FIRST(MSB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .serial_out(serial_out),
        .frame_active(frame_active),
        .stuff_out(stuff_out)
    );

    // Expected line for one accepted word, starting the cycle after acceptance.
    task automatic push_frame(input logic [DW-1:0] w);
        int ones = 0;
        logic [DW-1:0] sh;
        logic b;
        sbq.push_back(4'b0100);
        repeat (3) sbq.push_back(4'b1100);
        for (int i = 0; i < DW; i++) begin
            sh = w >> (MSB ? (DW - 1 - i) : i);
            b  = sh[0];
            if (STUFF && ones == 2) begin
                sbq.push_back(4'b0110);
                ones = 0;
            end
            sbq.push_back({b, 3'b100});
            ones = b ? ones + 1 : 0;
        end
        repeat (GAP) sbq.push_back(4'b0000);
    endtask

    function automatic exp_t next_exp();
        if (sbq.size() > 0) return sbq.pop_front();
        return IDLE_E;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({serial_out, frame_active, stuff_out, tx_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_state got=%b want=0001", {serial_out, frame_active, stuff_out, tx_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({serial_out, frame_active, stuff_out, tx_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=0001", {serial_out, frame_active, stuff_out, tx_ready});
        end
    endtask

    task automatic test_zero_word();
        exp_t e;
        logic [3:0] obs;
        int fa_n = 0;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        push_frame(8'h00);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL zero_word cyc=%0d got=%b want=%b", c, obs, e);
            end
            if (frame_active) fa_n++;
        end
        checks++;
        if (fa_n != 12) begin
            failures++;
            $display("FAIL zero_word_active_len got=%0d want=12", fa_n);
        end
    endtask

    task automatic test_all_ones();
        exp_t e;
        logic [3:0] obs;
        logic [31:0] bits = '0;
        logic [31:0] smask = '0;
        int n = 0;
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        push_frame(8'hFF);
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL all_ones cyc=%0d got=%b want=%b", c, obs, e);
            end
            if (frame_active) begin
                n++;
                bits = {bits[30:0], serial_out};
                if (stuff_out) smask = smask | (32'd1 << n);
            end
        end
`ifdef TX_BIT_STUFF_EN
        checks++;
        if (n != 15 || bits !== 32'h0000_3EDB) begin
            failures++;
            $display("FAIL all_ones_frame got len=%0d bits=%h want len=15 bits=00003edb", n, bits);
        end
        checks++;
        if (smask !== 32'h0000_2480) begin
            failures++;
            $display("FAIL all_ones_stuff_pos got=%h want=00002480", smask);
        end
`else
        checks++;
        if (n != 12 || bits !== 32'h0000_07FF) begin
            failures++;
            $display("FAIL all_ones_frame got len=%0d bits=%h want len=12 bits=000007ff", n, bits);
        end
        checks++;
        if (smask !== 32'h0) begin
            failures++;
            $display("FAIL all_ones_stuff_pos got=%h want=00000000", smask);
        end
`endif
    endtask

    task automatic test_stuff_pattern();
        exp_t e;
        logic [3:0] obs;
        logic [3:0] hist = '0;
        logic [31:0] smask = '0;
        int n = 0;
        int det = 0;
        int first_at = -1;
        tx_data = 8'h77;
        tx_valid = 1'b1;
        push_frame(8'h77);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            tx_data = 8'hFF;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pattern_77 cyc=%0d got=%b want=%b", c, obs, e);
            end
            if (frame_active) n++;
            if (stuff_out) smask = smask | (32'd1 << n);
            hist = {hist[2:0], serial_out};
            if (hist == 4'b0111) begin
                det++;
                if (first_at < 0) first_at = n;
            end
        end
        checks++;
        if (first_at != 4) begin
            failures++;
            $display("FAIL pattern_77_first_detect got=%0d want=4", first_at);
        end
`ifdef TX_BIT_STUFF_EN
        checks++;
        if (det != 1 || smask !== 32'h0000_2100) begin
            failures++;
            $display("FAIL pattern_77_detect got det=%0d mask=%h want det=1 mask=00002100", det, smask);
        end
`else
        checks++;
        if (det != 3 || smask !== 32'h0) begin
            failures++;
            $display("FAIL pattern_77_detect got det=%0d mask=%h want det=3 mask=00000000", det, smask);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] obs;
        int widx;
        int phase = 0;
        int zeros = 0;
        int rdy_n = 0;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        push_frame(8'hA5);
        widx = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", c, obs, e);
            end
            if (phase == 0 && frame_active) phase = 1;
            else if ((phase == 1 || phase == 2) && !frame_active) begin
                phase = 2;
                zeros++;
                if (tx_ready) rdy_n++;
            end else if (phase == 2 && frame_active) phase = 3;
            if (widx == 1 && tx_ready) begin
                push_frame(8'h3C);
                widx = 2;
            end else if (widx == 1) begin
                tx_data = 8'h3C;
            end else if (widx == 2) begin
                tx_valid = 1'b0;
            end
        end
        checks++;
        if (zeros != 3 || rdy_n != 1) begin
            failures++;
            $display("FAIL back_to_back_spacing got zeros=%0d ready=%0d want zeros=3 ready=1", zeros, rdy_n);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        logic [3:0] obs;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        push_frame(8'hA5);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_prefix cyc=%0d got=%b want=%b", c, obs, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({serial_out, frame_active, stuff_out, tx_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL abort_async got=%b want=0001", {serial_out, frame_active, stuff_out, tx_ready});
        end
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== IDLE_E) begin
                failures++;
                $display("FAIL abort_residual cyc=%0d got=%b want=%b", c, obs, IDLE_E);
            end
        end
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        push_frame(8'h3C);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_next_frame cyc=%0d got=%b want=%b", c, obs, e);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0] obs;
        logic [3:0] hist = '0;
        logic [DW-1:0] w;
        int sent = 0;
        int det = 0;
        int cyc = 0;
        tx_valid = 1'b0;
        while (!(sent == NW && sbq.size() == 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            e = next_exp();
            obs = {serial_out, frame_active, stuff_out, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            hist = {hist[2:0], serial_out};
            if (hist == 4'b0111) det++;
            if (tx_ready && sent < NW && $urandom_range(3, 0) != 0) begin
                w = DW'($urandom);
                tx_data = w;
                tx_valid = 1'b1;
                push_frame(w);
                sent++;
            end else begin
                tx_valid = 1'b0;
                tx_data = DW'($urandom);
            end
        end
        checks++;
        if (sent != NW || sbq.size() != 0) begin
            failures++;
            $display("FAIL random_timeout got sent=%0d pending=%0d want sent=%0d pending=0", sent, sbq.size(), NW);
        end
`ifdef TX_BIT_STUFF_EN
        checks++;
        if (det != NW) begin
            failures++;
            $display("FAIL random_detect got=%0d want=%0d", det, NW);
        end
`else
        checks++;
        if (det < NW) begin
            failures++;
            $display("FAIL random_detect got=%0d want>=%0d", det, NW);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_all_ones();
        test_stuff_pattern();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
